// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_if
// Brief    : IR-to-controller-to-datapath control bundle for mc_controller.
// Revision : 1.0  initial release
// ============================================================================
interface mc_if;
    logic [31:0] cmd;
    logic        pc_en;
    logic        ir_en;
    logic [1:0]  ExtOp;
    logic        RegWrite;
    logic [1:0]  RegDst;
    logic [1:0]  ALUSrc;
    logic        Branch;
    logic        MemWrite;
    logic [1:0]  RegSrc;
    logic        Jump;
    logic [3:0]  ALUCtrl;
    logic        hilo_sel;
    logic        HiLoWrite;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_busy;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  cmd,
        output pc_en, ir_en, ExtOp, RegWrite, RegDst, ALUSrc, Branch, MemWrite,
               RegSrc, Jump, ALUCtrl, hilo_sel, HiLoWrite, md_start, md_op,
               md_busy, illegal, state
    );

    modport slave (
        output cmd,
        input  pc_en, ir_en, ExtOp, RegWrite, RegDst, ALUSrc, Branch, MemWrite,
               RegSrc, Jump, ALUCtrl, hilo_sel, HiLoWrite, md_start, md_op,
               md_busy, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Multi-cycle MIPS control FSM with a non-blocking mult/div scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module mc_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mc_if.master      bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_busy, w_md_start;

    logic [5:0] w_opcode, w_funct;
    logic [4:0] w_rt;
    logic       w_nop;
    logic       w_alu, w_load, w_store, w_br, w_jmp, w_link, w_mdu, w_mf, w_mt, w_legal;
    logic [1:0] w_ext, w_regdst, w_alusrc, w_regsrc, w_md_op;
    logic [3:0] w_aluctrl;
    logic       w_hilo;

    assign w_opcode = bus.cmd[31:26];
    assign w_funct  = bus.cmd[5:0];
    assign w_rt     = bus.cmd[20:16];
    assign w_nop    = (bus.cmd == 32'd0);
    assign w_legal  = w_alu | w_load | w_store | w_br | w_jmp | w_link | w_mdu | w_mf | w_mt;
    assign w_busy   = (r_cnt != '0);

    always_comb begin
        w_alu = 1'b0; w_load = 1'b0; w_store = 1'b0; w_br = 1'b0; w_jmp = 1'b0;
        w_link = 1'b0; w_mdu = 1'b0; w_mf = 1'b0; w_mt = 1'b0;
        w_ext = 2'b00; w_regdst = 2'b00; w_alusrc = 2'b00; w_regsrc = 2'b00;
        w_aluctrl = 4'b0000; w_hilo = 1'b0; w_md_op = 2'b00;
        if (!w_nop) begin
            case (w_opcode)
                6'h00: begin
                    case (w_funct)
                        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                            w_alu     = 1'b1;
                            w_regdst  = 2'b01;
                            // Constant shifts take shamt; variable shifts take rs.
                            w_alusrc  = w_funct[2] ? 2'b00 : 2'b10;
                            w_aluctrl = (w_funct[1:0] == 2'b00) ? 4'b1000 :
                                        (w_funct[1:0] == 2'b10) ? 4'b1001 : 4'b1010;
                        end
                        6'h08: begin w_jmp = 1'b1; end
                        6'h09: begin w_link = 1'b1; w_regdst = 2'b01; w_regsrc = 2'b10; end
                        6'h10, 6'h12: begin
                            w_mf = 1'b1; w_regdst = 2'b01; w_regsrc = 2'b11; w_hilo = ~w_funct[1];
                        end
                        6'h11, 6'h13: begin w_mt = 1'b1; w_hilo = ~w_funct[1]; end
                        6'h18, 6'h19, 6'h1A, 6'h1B: begin w_mdu = 1'b1; w_md_op = w_funct[1:0]; end
                        6'h20, 6'h21: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0010; end
                        6'h22, 6'h23: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0011; end
                        6'h24: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0100; end
                        6'h25: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0101; end
                        6'h26: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0110; end
                        6'h27: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b0111; end
                        6'h2A: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b1100; end
                        6'h2B: begin w_alu = 1'b1; w_regdst = 2'b01; w_aluctrl = 4'b1101; end
                        default: ;
                    endcase
                end
                6'h01: begin
                    if (w_rt == 5'd0 || w_rt == 5'd1) begin
                        w_br = 1'b1; w_ext = 2'b11; w_aluctrl = 4'b0011;
                    end
                end
                6'h02: begin w_jmp = 1'b1; end
                6'h03: begin w_link = 1'b1; w_regdst = 2'b10; w_regsrc = 2'b10; end
                6'h04, 6'h05, 6'h06, 6'h07: begin
                    w_br = 1'b1; w_ext = 2'b11; w_aluctrl = 4'b0011;
                end
                6'h08, 6'h09: begin w_alu = 1'b1; w_alusrc = 2'b01; w_aluctrl = 4'b0010; end
                6'h0A: begin w_alu = 1'b1; w_alusrc = 2'b01; w_aluctrl = 4'b1100; end
                6'h0B: begin w_alu = 1'b1; w_alusrc = 2'b01; w_aluctrl = 4'b1101; end
                6'h0C: begin w_alu = 1'b1; w_alusrc = 2'b01; w_ext = 2'b01; w_aluctrl = 4'b0100; end
                6'h0D: begin w_alu = 1'b1; w_alusrc = 2'b01; w_ext = 2'b01; w_aluctrl = 4'b0101; end
                6'h0E: begin w_alu = 1'b1; w_alusrc = 2'b01; w_ext = 2'b01; w_aluctrl = 4'b0110; end
                // lui: rs is $0 by encoding, so add passes the shifted immediate.
                6'h0F: begin w_alu = 1'b1; w_alusrc = 2'b01; w_ext = 2'b10; w_aluctrl = 4'b0010; end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    w_load = 1'b1; w_alusrc = 2'b01; w_regsrc = 2'b01; w_aluctrl = 4'b0010;
                end
                6'h28, 6'h29, 6'h2B: begin
                    w_store = 1'b1; w_alusrc = 2'b01; w_aluctrl = 4'b0010;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    // Every strobe is gated by rst_n so nothing fires while reset is held.
    always_comb begin
        w_next        = r_state;
        bus.pc_en     = 1'b0;
        bus.ir_en     = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.HiLoWrite = 1'b0;
        bus.Branch    = 1'b0;
        bus.Jump      = 1'b0;
        bus.illegal   = 1'b0;
        w_md_start    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                bus.ir_en = rst_n;
                bus.pc_en = rst_n;
                w_next    = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_nop) begin
                    w_next = ST_FETCH;
                end else if (!w_legal) begin
                    bus.illegal = rst_n;
                    w_next      = ST_FETCH;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_br) begin
                    bus.Branch = rst_n; bus.pc_en = rst_n; w_next = ST_FETCH;
                end else if (w_jmp) begin
                    bus.Jump = rst_n; bus.pc_en = rst_n; w_next = ST_FETCH;
                end else if (w_link) begin
                    bus.Jump = rst_n; bus.pc_en = rst_n; w_next = ST_WB;
                end else if (w_load || w_store) begin
                    w_next = ST_MEM;
                end else if (w_mdu) begin
                    if (!w_busy) begin
                        w_md_start = rst_n;
                        w_next     = ST_FETCH;
                    end
                end else if (w_mf || w_mt) begin
                    if (!w_busy) w_next = ST_WB;
                end else if (w_alu) begin
                    w_next = ST_WB;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (w_store) begin
                    bus.MemWrite = rst_n; w_next = ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_WB: begin
                bus.RegWrite  = rst_n & (w_alu | w_load | w_link | w_mf);
                bus.HiLoWrite = rst_n & w_mt;
                w_next        = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // Issue never overlaps a nonzero count, so load and decrement are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_cnt <= '0;
        else if (w_md_start) r_cnt <= w_md_op[1] ? C_DIV_LOAD : C_MULT_LOAD;
        else if (w_busy)     r_cnt <= r_cnt - C_ONE;
    end

    assign bus.md_start = w_md_start;
    assign bus.md_busy  = w_busy;
    assign bus.md_op    = w_md_op;
    assign bus.ExtOp    = w_ext;
    assign bus.RegDst   = w_regdst;
    assign bus.ALUSrc   = w_alusrc;
    assign bus.RegSrc   = w_regsrc;
    assign bus.ALUCtrl  = w_aluctrl;
    assign bus.hilo_sel = w_hilo;
    assign bus.state    = r_state;
endmodule
`default_nettype wire
